intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_pkg.sv | 21 ++
 rtl/irq_sync_edge.sv | 28 ++
 rtl/intr_ctrl.sv | 143 ++++++++++++++
 tb/tb_intr_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and constants for the interrupt controller
package intr_pkg;

  localparam int         NUM_IRQ          = 4;
  localparam logic [9:0] VEC_BASE_DEFAULT = 10'h3FC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Index of the lowest set bit; index 0 carries the highest priority.
  function automatic logic [1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    lowest_set = 2'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer with rising-edge detect for one irq line
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  // s1/s2 resolve metastability; prev holds the last synchronized level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= irq;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - four-line prioritized, non-nesting interrupt controller
module intr_ctrl
  import intr_pkg::*;
#(
  parameter logic [9:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               ei,
  input  logic               di,
  input  logic               cpu_push,
  input  logic               cpu_pop,
  input  logic               reti,
  output logic               stack_push,
  output logic               stack_pop,
  output logic               s_intr,
  output logic               cpu_hold,
  output logic               vec_load,
  output logic               ret_load,
  output logic [9:0]         vec_addr,
  output logic               in_service,
  output logic [1:0]         active_id,
  output logic               reti_err
);

  state_e             state;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] ready;
  logic [NUM_IRQ-1:0] clear_vec;
  logic               gie;
  logic               take;
  logic               reti_ok;
  logic               reti_bad;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq[g]),
      .rise  (rise[g])
    );
  end

  // A fresh edge counts as pending in the cycle it is detected, so the take
  // decision lands right after the two synchronizer stages.
  assign ready     = (pending | rise) & mask;
  assign take      = (state == ST_IDLE) && gie && (|ready) && !cpu_push && !cpu_pop;
  assign reti_ok   = (state == ST_SERVICE) && reti;
  assign reti_bad  = (state != ST_SERVICE) && reti;
  assign clear_vec = (state == ST_ENTER) ? (NUM_IRQ'(1) << active_id) : '0;

  // Control FSM: IDLE -> ENTER (one cycle) -> SERVICE -> IDLE on reti
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (take) state <= ST_ENTER;
        ST_ENTER:   state <= ST_SERVICE;
        ST_SERVICE: if (reti) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Latch the winning line when the interrupt is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_id <= 2'd0;
    end else if (take) begin
      active_id <= lowest_set(ready);
    end
  end

  // Pending bits latch every edge regardless of mask/gie; a new edge beats the ENTER clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear_vec) | rise;
    end
  end

  // Mask register, global enable (di dominates ei) and sticky misuse flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= '0;
      gie      <= 1'b0;
      reti_err <= 1'b0;
    end else begin
      if (mask_we) mask <= mask_in;
      if (di) begin
        gie <= 1'b0;
      end else if (ei) begin
        gie <= 1'b1;
      end
      if (reti_bad) reti_err <= 1'b1;
    end
  end

  // Stack/PC strobes: CPU call/ret pass through except on ENTER and reti cycles
  always_comb begin
    stack_push = cpu_push;
    stack_pop  = cpu_pop;
    s_intr     = 1'b0;
    cpu_hold   = 1'b0;
    vec_load   = 1'b0;
    ret_load   = 1'b0;
    vec_addr   = '0;
    in_service = 1'b0;
    if (state == ST_ENTER) begin
      stack_push = 1'b1;
      stack_pop  = 1'b0;
      vec_load   = 1'b1;
      cpu_hold   = 1'b1;
      vec_addr   = VEC_BASE + 10'(active_id);
    end else if (state == ST_SERVICE) begin
      in_service = 1'b1;
      if (reti_ok) begin
        stack_push = 1'b0;
        stack_pop  = 1'b1;
        s_intr     = 1'b1;
        ret_load   = 1'b1;
      end
    end
    if (reset) begin
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      s_intr     = 1'b0;
      cpu_hold   = 1'b0;
      vec_load   = 1'b0;
      ret_load   = 1'b0;
      vec_addr   = '0;
      in_service = 1'b0;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ei;
  logic       di;
  logic       cpu_push;
  logic       cpu_pop;
  logic       reti;
  logic       stack_push;
  logic       stack_pop;
  logic       s_intr;
  logic       cpu_hold;
  logic       vec_load;
  logic       ret_load;
  logic [9:0] vec_addr;
  logic       in_service;
  logic [1:0] active_id;
  logic       reti_err;

  int checks   = 0;
  int failures = 0;

  logic [9:0] stk [0:63];
  logic [5:0] sp = 6'd0;
  logic [9:0] pc = 10'd37;
  logic [9:0] ret_val;

  always #5 clk = ~clk;

  intr_ctrl #(.VEC_BASE(10'h3FC)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .ei         (ei),
    .di         (di),
    .cpu_push   (cpu_push),
    .cpu_pop    (cpu_pop),
    .reti       (reti),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .s_intr     (s_intr),
    .cpu_hold   (cpu_hold),
    .vec_load   (vec_load),
    .ret_load   (ret_load),
    .vec_addr   (vec_addr),
    .in_service (in_service),
    .active_id  (active_id),
    .reti_err   (reti_err)
  );

  // Return-address stack model: stores PC+1, s_intr selects stored-1
  always @(posedge clk) begin
    if (!reset) begin
      if (stack_push) begin
        stk[sp] <= pc + 10'd1;
        sp      <= sp + 6'd1;
      end else if (stack_pop) begin
        sp <= sp - 6'd1;
      end
    end
  end

  assign ret_val = stk[sp - 6'd1] - {9'd0, s_intr};

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; irq = 4'h0; mask_we = 1'b0; mask_in = 4'h0;
    ei = 1'b0; di = 1'b0; cpu_push = 1'b1; cpu_pop = 1'b0; reti = 1'b0;
    cyc();
    chk("rst_stack_push", stack_push, 0);
    chk("rst_stack_pop",  stack_pop,  0);
    chk("rst_vec_load",   vec_load,   0);
    chk("rst_vec_addr",   vec_addr,   0);
    chk("rst_in_service", in_service, 0);
    chk("rst_active_id",  active_id,  0);
    chk("rst_reti_err",   reti_err,   0);
    cpu_push = 1'b0;
    reset = 1'b0;
    cyc();

    // Single line take: mask 0010, ei, irq[1] rises
    mask_we = 1'b1; mask_in = 4'b0010; ei = 1'b1;
    cyc();
    mask_we = 1'b0; ei = 1'b0; irq = 4'b0010;
    cyc();
    chk("t1_sync1_vec_load", vec_load, 0);
    cyc();
    chk("t1_sync2_vec_load", vec_load, 0);
    cyc();
    chk("t1_enter_vec_load",   vec_load,   1);
    chk("t1_enter_stack_push", stack_push, 1);
    chk("t1_enter_cpu_hold",   cpu_hold,   1);
    chk("t1_enter_vec_addr",   vec_addr,   10'h3FD);
    chk("t1_enter_active_id",  active_id,  1);
    cyc();
    chk("t1_svc_in_service", in_service, 1);
    chk("t1_svc_vec_load",   vec_load,   0);
    chk("t1_svc_cpu_hold",   cpu_hold,   0);
    cpu_push = 1'b1;
    #1;
    chk("t1_svc_push_pass", stack_push, 1);
    cyc();
    cpu_push = 1'b0; cpu_pop = 1'b1;
    #1;
    chk("t1_svc_pop_pass",   stack_pop, 1);
    chk("t1_svc_pop_s_intr", s_intr,    0);
    cyc();
    cpu_pop = 1'b0; reti = 1'b1;
    #1;
    chk("t1_reti_stack_pop", stack_pop,  1);
    chk("t1_reti_s_intr",    s_intr,     1);
    chk("t1_reti_ret_load",  ret_load,   1);
    chk("t1_reti_push",      stack_push, 0);
    chk("t1_reti_ret_pc",    ret_val,    10'd37);
    cyc();
    reti = 1'b0;
    #1;
    chk("t1_idle_in_service", in_service, 0);
    chk("t1_idle_ret_load",   ret_load,   0);
    chk("t1_idle_reti_err",   reti_err,   0);
    irq = 4'h0;

    // Two lines at once: id 1 first, id 3 after reti, no nesting
    mask_we = 1'b1; mask_in = 4'hF;
    cyc();
    mask_we = 1'b0;
    repeat (3) cyc();
    irq = 4'b1010;
    repeat (2) cyc();
    chk("t2_pre_vec_load", vec_load, 0);
    cyc();
    chk("t2_enter1_vec_load",  vec_load,  1);
    chk("t2_enter1_active_id", active_id, 1);
    chk("t2_enter1_vec_addr",  vec_addr,  10'h3FD);
    repeat (4) cyc();
    chk("t2_nonest_in_service", in_service, 1);
    chk("t2_nonest_vec_load",   vec_load,   0);
    reti = 1'b1;
    cyc();
    reti = 1'b0;
    #1;
    chk("t2_idle_in_service", in_service, 0);
    chk("t2_idle_vec_load",   vec_load,   0);
    cyc();
    chk("t2_enter3_vec_load",  vec_load,  1);
    chk("t2_enter3_vec_addr",  vec_addr,  10'h3FF);
    chk("t2_enter3_active_id", active_id, 3);
    cyc();
    reti = 1'b1;
    cyc();
    reti = 1'b0;
    irq = 4'h0;

    // Masked line pends; mask write uses old mask in its own cycle
    mask_we = 1'b1; mask_in = 4'h0;
    cyc();
    mask_we = 1'b0;
    repeat (3) cyc();
    irq = 4'b0100;
    repeat (5) cyc();
    chk("t3_masked_vec_load",   vec_load,   0);
    chk("t3_masked_in_service", in_service, 0);
    mask_we = 1'b1; mask_in = 4'b0100;
    cyc();
    mask_we = 1'b0;
    #1;
    chk("t3_oldmask_vec_load", vec_load, 0);
    cyc();
    chk("t3_enter_vec_load", vec_load, 1);
    chk("t3_enter_vec_addr", vec_addr, 10'h3FE);
    cyc();
    reti = 1'b1;
    cyc();
    reti = 1'b0;
    irq = 4'h0;
    repeat (3) cyc();

    // cpu_push blocks the take until it drops
    mask_we = 1'b1; mask_in = 4'hF;
    cyc();
    mask_we = 1'b0; cpu_push = 1'b1; irq = 4'b0001;
    repeat (3) cyc();
    chk("t4_blocked_vec_load", vec_load,   0);
    chk("t4_blocked_push",     stack_push, 1);
    cyc();
    chk("t4_blocked2_vec_load", vec_load, 0);
    cpu_push = 1'b0;
    #1;
    chk("t4_drop_vec_load", vec_load, 0);
    cyc();
    chk("t4_enter_vec_load",  vec_load,  1);
    chk("t4_enter_vec_addr",  vec_addr,  10'h3FC);
    chk("t4_enter_active_id", active_id, 0);
    cyc();
    chk("t4_svc_in_service", in_service, 1);

    // Reset mid-SERVICE
    irq = 4'h0;
    reset = 1'b1;
    #1;
    chk("t5_rst_in_service", in_service, 0);
    chk("t5_rst_active_id",  active_id,  0);
    chk("t5_rst_stack_pop",  stack_pop,  0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("t5_post_in_service", in_service, 0);
    chk("t5_post_vec_load",   vec_load,   0);

    // reti in IDLE: ignored, sticky error
    reti = 1'b1;
    #1;
    chk("t6_reti_idle_pop",    stack_pop, 0);
    chk("t6_reti_idle_s_intr", s_intr,    0);
    chk("t6_reti_idle_load",   ret_load,  0);
    cyc();
    reti = 1'b0;
    #1;
    chk("t6_reti_err_set", reti_err, 1);
    repeat (3) cyc();
    chk("t6_reti_err_sticky", reti_err, 1);

    // ei and di together leave gie clear; pending still latches
    mask_we = 1'b1; mask_in = 4'hF; ei = 1'b1; di = 1'b1;
    cyc();
    mask_we = 1'b0; ei = 1'b0; di = 1'b0; irq = 4'b0010;
    repeat (5) cyc();
    chk("t7_gie_off_vec_load", vec_load,   0);
    chk("t7_gie_off_service",  in_service, 0);
    ei = 1'b1;
    cyc();
    ei = 1'b0;
    #1;
    chk("t7_gie_on_vec_load", vec_load, 0);
    cyc();
    chk("t7_enter_vec_load", vec_load, 1);
    chk("t7_enter_vec_addr", vec_addr, 10'h3FD);
    reset = 1'b1;
    cyc();
    chk("t7_rst_reti_err", reti_err, 0);
    reset = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
